pusch_symbol_scheduler: RTL

- Slot-level controller that sequences resource-element mapping for one PUSCH slot, symbol by symbol from sym_start to sym_end.
- For each symbol it selects the source: the FFT output memory for data symbols, or the DMRS memory for symbols flagged in dmrs_mask.
- It generates read addresses for the selected source and write addresses for the IFFT ping-pong buffer, offset by n_sc_start.
- It hands each completed symbol to IFFT_CP with a one-cycle pulse. Sits between FFT/DMRS memories and the REM/IFFT buffer.

---
 rtl/pusch_sched_pkg.sv | 31 +++
 rtl/pusch_symbol_scheduler_if.sv | 36 +++
 rtl/sched_addr_gen.sv | 82 ++++++++
 rtl/pusch_symbol_scheduler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pusch_sched_pkg.sv
// rtl/pusch_sched_pkg.sv - shared types and constants for the PUSCH symbol scheduler
// Holds the scheduler state enum, grid constants and the per-symbol
// subcarrier count helper. Macro PUSCH_SCHED_ZERO_FILL_EN adds S_CLEAR.
package pusch_sched_pkg;

  localparam int NFFT       = 2048;
  localparam int ADDR_W     = 11;
  localparam int SC_PER_RB  = 12;
  localparam int N_SYM_SLOT = 14;
  localparam int DMRS_AW    = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SRC,
    S_WAIT_BUF,
`ifdef PUSCH_SCHED_ZERO_FILL_EN
    S_CLEAR,
`endif
    S_MAP,
    S_DRAIN,
    S_DONE
  } state_t;

  // Subcarriers mapped per symbol; 127 RBs * 12 = 1524 still fits 11 bits.
  function automatic logic [10:0] calc_m(input logic [6:0] n_rb);
    logic [10:0] m;
    m = 11'(n_rb) * 11'(SC_PER_RB);
    return m;
  endfunction

endpackage

// File: rtl/pusch_symbol_scheduler_if.sv
// rtl/pusch_symbol_scheduler_if.sv - memory-side read/write bus of the PUSCH symbol scheduler
// Signals: data_rd_en/data_rd_addr (FFT memory read), dmrs_rd_en/dmrs_rd_addr
// (DMRS memory read), wr_en/wr_addr/wr_sel (IFFT buffer write), and wr_zero
// (zero-fill write, only with PUSCH_SCHED_ZERO_FILL_EN).
// Modports: master = scheduler side (drives), slave = memory side.
interface pusch_symbol_scheduler_if;
  import pusch_sched_pkg::*;

  logic               data_rd_en;
  logic [ADDR_W-1:0]  data_rd_addr;
  logic               dmrs_rd_en;
  logic [DMRS_AW-1:0] dmrs_rd_addr;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               wr_sel;
`ifdef PUSCH_SCHED_ZERO_FILL_EN
  logic               wr_zero;
`endif

  modport master (
    output data_rd_en, data_rd_addr, dmrs_rd_en, dmrs_rd_addr,
    output wr_en, wr_addr, wr_sel
`ifdef PUSCH_SCHED_ZERO_FILL_EN
    , output wr_zero
`endif
  );

  modport slave (
    input data_rd_en, data_rd_addr, dmrs_rd_en, dmrs_rd_addr,
    input wr_en, wr_addr, wr_sel
`ifdef PUSCH_SCHED_ZERO_FILL_EN
    , input wr_zero
`endif
  );

endinterface

// File: rtl/sched_addr_gen.sv
// rtl/sched_addr_gen.sv - subcarrier counter, read address counters and write pipeline
// Ports: clk, reset (sync, active-high); slot_start clears the data read
// counter; rd_go issues one read this cycle, is_dmrs selects the source;
// cnt_run/cnt_last advance and wrap k; n_sc_start offsets the write address;
// k is the current subcarrier index; mem is the memory-side bus (master).
// With PUSCH_SCHED_ZERO_FILL_EN, clr_go writes zero to address k.
module sched_addr_gen
  import pusch_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              slot_start,
  input  logic              rd_go,
  input  logic              is_dmrs,
  input  logic              cnt_run,
  input  logic              cnt_last,
`ifdef PUSCH_SCHED_ZERO_FILL_EN
  input  logic              clr_go,
`endif
  input  logic [ADDR_W-1:0] n_sc_start,
  output logic [ADDR_W-1:0] k,
  pusch_symbol_scheduler_if.master mem
);

  logic [ADDR_W-1:0] data_cnt;
  logic [ADDR_W:0]   wr_sum;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_sel_q;
`ifdef PUSCH_SCHED_ZERO_FILL_EN
  logic              wr_zero_q;
`endif

  // One bit of headroom, then natural truncation gives the modulo-NFFT wrap.
  assign wr_sum = {1'b0, n_sc_start} + {1'b0, k};

  always_ff @(posedge clk) begin
    if (reset) begin
      k         <= '0;
      data_cnt  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_sel_q  <= 1'b0;
`ifdef PUSCH_SCHED_ZERO_FILL_EN
      wr_zero_q <= 1'b0;
`endif
    end else begin
      k <= (cnt_run && !cnt_last) ? k + 1'b1 : '0;

      // Data reads continue across symbols of one slot; only a new slot rewinds.
      if (slot_start)
        data_cnt <= '0;
      else if (rd_go && !is_dmrs)
        data_cnt <= data_cnt + 1'b1;

      // Read latency is one cycle, so the write trails its read by one cycle.
      wr_en_q  <= rd_go;
      wr_sel_q <= rd_go && is_dmrs;
      if (rd_go)
        wr_addr_q <= wr_sum[ADDR_W-1:0];
`ifdef PUSCH_SCHED_ZERO_FILL_EN
      wr_zero_q <= clr_go;
      if (clr_go) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= k;
      end
`endif
    end
  end

  assign mem.data_rd_en   = rd_go && !is_dmrs;
  assign mem.data_rd_addr = data_cnt;
  assign mem.dmrs_rd_en   = rd_go && is_dmrs;
  assign mem.dmrs_rd_addr = k[DMRS_AW-1:0];
  assign mem.wr_en        = wr_en_q;
  assign mem.wr_addr      = wr_addr_q;
  assign mem.wr_sel       = wr_sel_q;
`ifdef PUSCH_SCHED_ZERO_FILL_EN
  assign mem.wr_zero      = wr_zero_q;
`endif

endmodule

// File: rtl/pusch_symbol_scheduler.sv
// rtl/pusch_symbol_scheduler.sv - per-slot PUSCH resource-element mapping sequencer
// Ports: clk, reset (sync, active-high); start + configuration (n_rb,
// n_sc_start, sym_start, sym_end, dmrs_mask) latched in IDLE; fft_done,
// dmrs_done source-ready indications; ifft_ready buffer-free indication;
// sym_idx/sym_valid symbol hand-off; busy, done, cfg_err status;
// mem = read/write bus towards FFT/DMRS memories and the IFFT buffer.
// Macro PUSCH_SCHED_ZERO_FILL_EN inserts a full-grid zero write before MAP.
module pusch_symbol_scheduler
  import pusch_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  n_rb,
  input  logic [10:0] n_sc_start,
  input  logic [3:0]  sym_start,
  input  logic [3:0]  sym_end,
  input  logic [13:0] dmrs_mask,
  input  logic        fft_done,
  input  logic        dmrs_done,
  input  logic        ifft_ready,
  output logic [3:0]  sym_idx,
  output logic        sym_valid,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  pusch_symbol_scheduler_if.master mem
);

  state_t            state, state_n;
  logic [3:0]        sym;
  logic [ADDR_W-1:0] n_sc_q;
  logic [10:0]       m_q;
  logic [3:0]        sym_end_q;
  logic [13:0]       mask_q;
  logic              cfg_bad_q;
  logic              fft_seen, dmrs_seen;
  logic              drain_ph;

  logic              cfg_bad;
  logic              is_dmrs;
  logic              slot_start, rd_go, cnt_run, cnt_last;
  logic [ADDR_W-1:0] k;
`ifdef PUSCH_SCHED_ZERO_FILL_EN
  logic              clr_go;
`endif

  assign cfg_bad = (sym_start > sym_end) || (sym_end > 4'(N_SYM_SLOT - 1)) || (n_rb == 7'd0);
  assign is_dmrs = mask_q[sym];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sym       <= '0;
      n_sc_q    <= '0;
      m_q       <= '0;
      sym_end_q <= '0;
      mask_q    <= '0;
      cfg_bad_q <= 1'b0;
      fft_seen  <= 1'b0;
      dmrs_seen <= 1'b0;
      drain_ph  <= 1'b0;
    end else begin
      state <= state_n;
      // DRAIN spans two cycles: last write, then the sym_valid hand-off.
      drain_ph <= (state == S_DRAIN) && !drain_ph;
      if (state == S_DONE) begin
        fft_seen  <= 1'b0;
        dmrs_seen <= 1'b0;
      end else begin
        fft_seen  <= fft_seen | fft_done;
        dmrs_seen <= dmrs_seen | dmrs_done;
      end
      if (slot_start) begin
        sym       <= sym_start;
        n_sc_q    <= n_sc_start;
        m_q       <= calc_m(n_rb);
        sym_end_q <= sym_end;
        mask_q    <= dmrs_mask;
        cfg_bad_q <= cfg_bad;
      end else if (sym_valid && (sym != sym_end_q)) begin
        sym <= sym + 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    slot_start = 1'b0;
    rd_go      = 1'b0;
    cnt_run    = 1'b0;
    cnt_last   = 1'b0;
    sym_valid  = 1'b0;
`ifdef PUSCH_SCHED_ZERO_FILL_EN
    clr_go     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          slot_start = 1'b1;
          state_n    = cfg_bad ? S_DONE : S_WAIT_SRC;
        end
      end
      S_WAIT_SRC: begin
        if (is_dmrs ? dmrs_seen : fft_seen)
          state_n = S_WAIT_BUF;
      end
      S_WAIT_BUF: begin
        if (ifft_ready) begin
`ifdef PUSCH_SCHED_ZERO_FILL_EN
          state_n = S_CLEAR;
`else
          state_n = S_MAP;
`endif
        end
      end
`ifdef PUSCH_SCHED_ZERO_FILL_EN
      S_CLEAR: begin
        clr_go   = 1'b1;
        cnt_run  = 1'b1;
        cnt_last = (k == ADDR_W'(NFFT - 1));
        if (cnt_last)
          state_n = S_MAP;
      end
`endif
      S_MAP: begin
        rd_go    = 1'b1;
        cnt_run  = 1'b1;
        cnt_last = (k == (m_q - 11'd1));
        if (cnt_last)
          state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_ph) begin
          sym_valid = 1'b1;
          state_n   = (sym == sym_end_q) ? S_DONE : S_WAIT_SRC;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign sym_idx = sym;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign cfg_err = (state == S_DONE) && cfg_bad_q;

  sched_addr_gen u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .slot_start (slot_start),
    .rd_go      (rd_go),
    .is_dmrs    (is_dmrs),
    .cnt_run    (cnt_run),
    .cnt_last   (cnt_last),
`ifdef PUSCH_SCHED_ZERO_FILL_EN
    .clr_go     (clr_go),
`endif
    .n_sc_start (n_sc_q),
    .k          (k),
    .mem        (mem)
  );

endmodule
